// File: rtl/decode_arbiter_pkg.sv
// Shared types and lookup constants for the two-requester code decoder.
package decode_arb_pkg;

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    typedef logic       req_id_t;
    typedef logic [5:0] code_t;
    typedef logic [2:0] sym_t;

    typedef struct packed {
        logic hit;
        sym_t sym;
    } lut_out_t;

    localparam code_t CODE_A = 6'b101010;
    localparam sym_t  SYM_A  = 3'b111;
    localparam code_t CODE_B = 6'b101100;
    localparam sym_t  SYM_B  = 3'b010;
    localparam code_t CODE_C = 6'b101101;
    localparam sym_t  SYM_C  = 3'b110;
    localparam code_t CODE_D = 6'b011011;
    localparam sym_t  SYM_D  = 3'b011;
    localparam code_t CODE_E = 6'b101111;
    localparam sym_t  SYM_E  = 3'b001;

endpackage

// File: rtl/decode_arbiter_if.sv
// Request/response handshake bundle between two code sources, the arbiter and one consumer.
interface decode_arbiter_if #(
    parameter int DW = 6,
    parameter int OW = 3
);
    logic          req0_valid;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          rsp_valid;
    logic [OW-1:0] rsp_data;
    logic          rsp_hit;
    logic          rsp_id;
    logic          rsp_ready;
    logic          busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_hit, rsp_id, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_hit, rsp_id, busy
    );
endinterface

// File: rtl/decode_arbiter_code_lut.sv
// Exact-match 6-bit code to 3-bit symbol table; combinational, no backpressure.
// Unlisted codes return symbol 000 with hit cleared.
module code_lut
    import decode_arb_pkg::*;
(
    input  code_t    code,
    output lut_out_t result
);

    always_comb begin
        result = '0;
        case (code)
            CODE_A:  result = '{hit: 1'b1, sym: SYM_A};
            CODE_B:  result = '{hit: 1'b1, sym: SYM_B};
            CODE_C:  result = '{hit: 1'b1, sym: SYM_C};
            CODE_D:  result = '{hit: 1'b1, sym: SYM_D};
            CODE_E:  result = '{hit: 1'b1, sym: SYM_E};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/decode_arbiter.sv
// Round-robin shares one code lookup between two requesters; accept to rsp_valid is 2 cycles,
// response held until rsp_ready, no new accept while busy. DEC_STATS_EN adds per-requester miss counters.
module decode_arbiter
    import decode_arb_pkg::*;
#(
    parameter int DW = 6,
    parameter int OW = 3
`ifdef DEC_STATS_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic clk,
    input  logic rst,
    decode_arbiter_if.slave bus
`ifdef DEC_STATS_EN
    ,
    output logic [CNT_W-1:0] miss_cnt0,
    output logic [CNT_W-1:0] miss_cnt1
`endif
);

    state_t        state, state_nxt;
    req_id_t       last_grant, grant_id, id_q;
    logic          grant_vld;
    logic [DW-1:0] code_q;
    lut_out_t      lut_out;
    logic [OW-1:0] rsp_data_q;
    logic          rsp_hit_q;
    req_id_t       rsp_id_q;
    logic          rsp_hs;

    code_lut u_lut (
        .code   (code_q),
        .result (lut_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld)     state_nxt = LOOKUP;
            LOOKUP:                     state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Ready is gated by rst so nothing is offered while reset is asserted.
    always_comb begin
        grant_vld      = 1'b0;
        grant_id       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        if (state == IDLE && !rst) begin
            grant_vld = bus.req0_valid | bus.req1_valid;
            if (bus.req0_valid && bus.req1_valid) grant_id = ~last_grant;
            else                                  grant_id = bus.req1_valid;
            bus.req0_ready = grant_vld & ~grant_id;
            bus.req1_ready = grant_vld &  grant_id;
        end
    end

    assign rsp_hs        = (state == RESP) && bus.rsp_ready;
    assign bus.rsp_valid = (state == RESP);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_id    = rsp_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            code_q     <= '0;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            if (grant_vld) begin
                code_q <= grant_id ? bus.req1_data : bus.req0_data;
                id_q   <= grant_id;
            end
            if (state == LOOKUP) begin
                rsp_data_q <= lut_out.sym;
                rsp_hit_q  <= lut_out.hit;
                rsp_id_q   <= id_q;
            end
            if (rsp_hs) last_grant <= rsp_id_q;
        end
    end

`ifdef DEC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt0 <= '0;
            miss_cnt1 <= '0;
        end else if (rsp_hs && !rsp_hit_q) begin
            if (!rsp_id_q && miss_cnt0 != '1) miss_cnt0 <= miss_cnt0 + 1'b1;
            if ( rsp_id_q && miss_cnt1 != '1) miss_cnt1 <= miss_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_arbiter.sv
// Self-checking bench for decode_arbiter: table vectors, code sweep and handshake corner cases.
module tb_decode_arbiter;
    import decode_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_arbiter_if #(.DW(6), .OW(3)) bus ();

`ifdef DEC_STATS_EN
    logic [7:0] miss_cnt0, miss_cnt1;
    decode_arbiter dut (.clk(clk), .rst(rst), .bus(bus), .miss_cnt0(miss_cnt0), .miss_cnt1(miss_cnt1));
`else
    decode_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct {
        logic       id;
        logic [2:0] data;
        logic       hit;
    } exp_t;

    typedef struct {
        logic       id;
        logic [5:0] code;
        logic [2:0] data;
        logic       hit;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [5:0] code);
        exp_t e;
        e.id = id;
        e.hit = 1'b1;
        case (code)
            6'b101010: e.data = 3'b111;
            6'b101100: e.data = 3'b010;
            6'b101101: e.data = 3'b110;
            6'b011011: e.data = 3'b011;
            6'b101111: e.data = 3'b001;
            default: begin e.data = 3'b000; e.hit = 1'b0; end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", bus.rsp_id, e.id);
                check("rsp_data", bus.rsp_data, e.data);
                check("rsp_hit", bus.rsp_hit, e.hit);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic id, input logic [5:0] code, input exp_t e);
        bit ok = 0;
        if (id) begin bus.req1_valid = 1'b1; bus.req1_data = code; end
        else    begin bus.req0_valid = 1'b1; bus.req0_data = code; end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                sb.push_back(e);
                ok = 1;
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check("drain", sb.size(), 0);
    endtask

    task automatic wait_rsp_valid();
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1;
            else tick();
        end
        check("rsp_valid_timeout", seen, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    vec_t vt[9];
    int   grants;
    logic exp_g;

    initial begin
        vt[0] = '{1'b0, 6'b101010, 3'b111, 1'b1};
        vt[1] = '{1'b1, 6'b101100, 3'b010, 1'b1};
        vt[2] = '{1'b0, 6'b101101, 3'b110, 1'b1};
        vt[3] = '{1'b1, 6'b011011, 3'b011, 1'b1};
        vt[4] = '{1'b0, 6'b101111, 3'b001, 1'b1};
        vt[5] = '{1'b1, 6'b101110, 3'b000, 1'b0};
        vt[6] = '{1'b0, 6'b000000, 3'b000, 1'b0};
        vt[7] = '{1'b1, 6'b111111, 3'b000, 1'b0};
        vt[8] = '{1'b0, 6'b101011, 3'b000, 1'b0};

        bus.req0_valid = 1'b1; bus.req0_data = 6'b101010;
        bus.req1_valid = 1'b1; bus.req1_data = 6'b011011;
        bus.rsp_ready  = 1'b1;

        // Outputs quiet during reset even with requests pending
        repeat (2) @(negedge clk);
        check("rst_req0_ready", bus.req0_ready, 0);
        check("rst_req1_ready", bus.req1_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_hit", bus.rsp_hit, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_valid", bus.rsp_valid, 0);
        check("post_rst_busy", bus.busy, 0);
        tick();

        // Latency: accept at cycle 0, response at cycle 2
        bus.req0_valid = 1'b1; bus.req0_data = 6'b101010;
        @(negedge clk);
        check("lat_c0_ready", bus.req0_ready, 1);
        sb.push_back('{1'b0, 3'b111, 1'b1});
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("lat_c1_rsp_valid", bus.rsp_valid, 0);
        check("lat_c1_busy", bus.busy, 1);
        @(negedge clk);
        check("lat_c2_rsp_valid", bus.rsp_valid, 1);
        tick();
        drain();

        for (int i = 0; i < 9; i++) send(vt[i].id, vt[i].code, '{vt[i].id, vt[i].data, vt[i].hit});
        drain();

        // Both requesters held valid: grants must alternate starting with req0
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_data = 6'b101100;
        bus.req1_valid = 1'b1; bus.req1_data = 6'b011011;
        grants = 0;
        exp_g  = 1'b0;
        for (int c = 0; c < 40 && grants < 6; c++) begin
            @(negedge clk);
            check("both_ready", bus.req0_ready & bus.req1_ready, 0);
            if (bus.req0_ready || bus.req1_ready) begin
                check("grant_order", bus.req1_ready, exp_g);
                if (bus.req1_ready) sb.push_back('{1'b1, 3'b011, 1'b1});
                else                sb.push_back('{1'b0, 3'b010, 1'b1});
                exp_g = ~exp_g;
                grants++;
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("grant_count", grants, 6);
        drain();

        // Consumer stalls five cycles; a transient req0 must not be latched
        bus.rsp_ready = 1'b0;
        send(1'b1, 6'b101111, '{1'b1, 3'b001, 1'b1});
        wait_rsp_valid();
        for (int c = 0; c < 5; c++) begin
            tick();
            bus.req0_valid = 1'b1; bus.req0_data = 6'b101010;
            @(negedge clk);
            check("stall_rsp_valid", bus.rsp_valid, 1);
            check("stall_rsp_data", bus.rsp_data, 3'b001);
            check("stall_rsp_hit", bus.rsp_hit, 1);
            check("stall_rsp_id", bus.rsp_id, 1);
            check("stall_req0_ready", bus.req0_ready, 0);
            check("stall_req1_ready", bus.req1_ready, 0);
            check("stall_busy", bus.busy, 1);
        end
        tick();
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        drain();

        // Reset while a response is pending; afterwards req0 wins a tie
        bus.rsp_ready = 1'b0;
        send(1'b1, 6'b101101, '{1'b1, 3'b110, 1'b1});
        wait_rsp_valid();
        #1;
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_rsp_data", bus.rsp_data, 0);
        sb.delete();
        bus.req0_valid = 1'b1; bus.req0_data = 6'b101100;
        bus.req1_valid = 1'b1; bus.req1_data = 6'b101010;
        bus.rsp_ready  = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check("midrst_grant0", bus.req0_ready, 1);
        check("midrst_grant1", bus.req1_ready, 0);
        sb.push_back('{1'b0, 3'b010, 1'b1});
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();

        for (int c = 0; c < 64; c++) begin
            logic [5:0] code;
            code = 6'(c);
            send(code[0], code, model(code[0], code));
        end
        drain();

`ifdef DEC_STATS_EN
        do_reset();
        for (int c = 0; c < 256; c++) send(1'b1, 6'b000000, '{1'b1, 3'b000, 1'b0});
        drain();
        repeat (2) tick();
        check("miss_cnt1_sat", miss_cnt1, 8'd255);
        check("miss_cnt0_zero", miss_cnt0, 8'd0);
`endif

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
